// File: rtl/io_mem_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : io_mem_bridge_pkg
//  Purpose  : Shared constants, register-select type and IO address decode
//             helper for the memory/IO access stage.
//  Revision : 1.0  initial release
// ============================================================================
package io_mem_bridge_pkg;

    // Upper 22 address bits that mark the memory-mapped IO window.
    localparam logic [21:0] C_IO_PREFIX = 22'h3FFFFF;

    // Register offsets within the IO window (addr[7:0]).
    localparam logic [7:0]  C_OFF_LED   = 8'h60;
    localparam logic [7:0]  C_OFF_SW    = 8'h70;
    localparam logic [7:0]  C_OFF_DISP  = 8'h80;
    localparam logic [7:0]  C_OFF_KEY   = 8'h90;

    // All segments (including the decimal point) dark, active-low.
    localparam logic [7:0]  C_SEG_OFF   = 8'hFF;

    typedef enum logic [2:0] {
        IO_NONE = 3'd0,
        IO_LED  = 3'd1,
        IO_SW   = 3'd2,
        IO_DISP = 3'd3,
        IO_KEY  = 3'd4
    } io_reg_e;

    // Map an address (prefix + low offset byte) to the peripheral register it
    // selects. Anything outside the IO window or at an unmapped offset is
    // IO_NONE.
    function automatic io_reg_e io_decode(input logic [21:0] prefix,
                                          input logic [7:0]  offset);
        io_reg_e sel;
        sel = IO_NONE;
        if (prefix == C_IO_PREFIX) begin
            case (offset)
                C_OFF_LED:  sel = IO_LED;
                C_OFF_SW:   sel = IO_SW;
                C_OFF_DISP: sel = IO_DISP;
                C_OFF_KEY:  sel = IO_KEY;
                default:    sel = IO_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_mem_bridge_hex7seg.sv
`default_nettype none
// ============================================================================
//  Module   : hex7seg
//  Purpose  : Combinational hex nibble to seven-segment decoder, active-low.
//  Ports    : i_nibble [3:0]  value to display
//             o_seg    [6:0]  segments {g,f,e,d,c,b,a}, 0 = lit
//  Revision : 1.0  initial release
// ============================================================================
module hex7seg (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h7F;
        case (i_nibble)
            4'h0: o_seg = 7'h40;
            4'h1: o_seg = 7'h79;
            4'h2: o_seg = 7'h24;
            4'h3: o_seg = 7'h30;
            4'h4: o_seg = 7'h19;
            4'h5: o_seg = 7'h12;
            4'h6: o_seg = 7'h02;
            4'h7: o_seg = 7'h78;
            4'h8: o_seg = 7'h00;
            4'h9: o_seg = 7'h10;
            4'hA: o_seg = 7'h08;
            4'hB: o_seg = 7'h03;
            4'hC: o_seg = 7'h46;
            4'hD: o_seg = 7'h21;
            4'hE: o_seg = 7'h06;
            4'hF: o_seg = 7'h0E;
            default: o_seg = 7'h7F;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/io_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : io_mem_bridge
//  Purpose  : Memory/IO access stage of the single-cycle MIPS datapath.
//             Steers load data from data memory or peripheral registers and
//             owns the LED latch, switch input, key press flag and the
//             multiplexed 8-digit seven-segment display.
//  Ports    : clock, reset            clock / async active-high reset
//             mem_read, mem_write,
//             io_read, io_write       access strobes (one-hot or idle)
//             addr_in    [31:0]       ALU byte address
//             m_rdata    [31:0]       data-memory read data
//             r_rdata    [31:0]       store data (register rt)
//             switch_in  [23:0]       board switches
//             key_in                  asynchronous board key
//             addr_out   [31:0]       address to data memory
//             write_data [31:0]       store data to memory
//             r_wdata    [31:0]       load data to register file
//             led_out    [23:0]       LED register
//             seg_an     [7:0]        digit enables, active-low
//             seg_out    [7:0]        {dp,g,f,e,d,c,b,a}, active-low
//  Revision : 1.0  initial release
// ============================================================================
module io_mem_bridge
    import io_mem_bridge_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        io_read,
    input  logic        io_write,
    input  logic [31:0] addr_in,
    input  logic [31:0] m_rdata,
    input  logic [31:0] r_rdata,
    input  logic [23:0] switch_in,
    input  logic        key_in,
    output logic [31:0] addr_out,
    output logic [31:0] write_data,
    output logic [31:0] r_wdata,
    output logic [23:0] led_out,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_out
);

    localparam int                 CNT_W      = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]   C_CNT_LAST = CNT_W'(SCAN_DIV - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [23:0]      r_led;
    logic [31:0]      r_disp;
    logic             r_key_s1;
    logic             r_key_s2;
    logic             r_key_prev;
    logic             r_key_flag;
    logic [CNT_W-1:0] r_scan_cnt;
    logic [2:0]       r_digit;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    io_reg_e          w_sel;
    logic             w_key_rise;
    logic             w_key_clr;
    logic [31:0]      w_io_rdata;
    logic [3:0]       w_nibble;
    logic [6:0]       w_seg7;
    logic [1:0]       w_unused_addr;

    // Offsets decode only addr[7:0]; bits 9:8 are don't-care inside the window.
    assign w_unused_addr = addr_in[9:8];

    assign w_sel      = io_decode(addr_in[31:10], addr_in[7:0]);
    assign w_key_rise = r_key_s2 & ~r_key_prev;
    assign w_key_clr  = io_read && (w_sel == IO_KEY);

    // ------------------------------------------------------------------
    // Datapath outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_io_rdata = 32'h0;
        case (w_sel)
            IO_LED:  w_io_rdata = {8'h00, r_led};
            IO_SW:   w_io_rdata = {8'h00, switch_in};
            IO_DISP: w_io_rdata = r_disp;
            IO_KEY:  w_io_rdata = {31'h0, r_key_flag};
            default: w_io_rdata = 32'h0;
        endcase
    end

    always_comb begin
        r_wdata = 32'h0;
        if (mem_read) begin
            r_wdata = m_rdata;
        end else if (io_read) begin
            r_wdata = w_io_rdata;
        end
    end

    assign addr_out   = addr_in;
    assign write_data = (mem_write || io_write) ? r_rdata : 32'h0;
    assign led_out    = r_led;

    // ------------------------------------------------------------------
    // Writable peripheral registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_led  <= 24'h0;
            r_disp <= 32'h0;
        end else if (io_write) begin
            case (w_sel)
                IO_LED:  r_led  <= r_rdata[23:0];
                IO_DISP: r_disp <= r_rdata;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Key path: two-flop synchronizer, edge detect, read-to-clear flag.
    // A new edge in the same cycle as the clearing read keeps the flag set
    // so the press is never lost.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_key_s1   <= 1'b0;
            r_key_s2   <= 1'b0;
            r_key_prev <= 1'b0;
            r_key_flag <= 1'b0;
        end else begin
            r_key_s1   <= key_in;
            r_key_s2   <= r_key_s1;
            r_key_prev <= r_key_s2;
            if (w_key_rise) begin
                r_key_flag <= 1'b1;
            end else if (w_key_clr) begin
                r_key_flag <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Display scan: each digit dwells SCAN_DIV cycles; index wraps 7 -> 0
    // naturally through its 3-bit width.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_scan_cnt <= '0;
            r_digit    <= 3'd0;
        end else if (r_scan_cnt == C_CNT_LAST) begin
            r_scan_cnt <= '0;
            r_digit    <= r_digit + 3'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    assign w_nibble = r_disp[{r_digit, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .i_nibble (w_nibble),
        .o_seg    (w_seg7)
    );

    assign seg_an  = ~(8'h01 << r_digit);
    assign seg_out = {C_SEG_OFF[7], w_seg7};

endmodule
`default_nettype wire

// File: tb/tb_io_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_io_mem_bridge
//  Purpose  : Directed self-checking bench for io_mem_bridge (SCAN_DIV = 4).
//             Expected values are queued when stimulus is applied and popped
//             when the corresponding DUT output is sampled.
//  Revision : 1.0  initial release
// ============================================================================
module tb_io_mem_bridge;

    localparam int SCAN_DIV = 4;

    logic        clock;
    logic        reset;
    logic        mem_read, mem_write, io_read, io_write;
    logic [31:0] addr_in, m_rdata, r_rdata;
    logic [23:0] switch_in;
    logic        key_in;
    logic [31:0] addr_out, write_data, r_wdata;
    logic [23:0] led_out;
    logic [7:0]  seg_an, seg_out;

    io_mem_bridge #(.SCAN_DIV(SCAN_DIV)) dut (
        .clock      (clock),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .io_read    (io_read),
        .io_write   (io_write),
        .addr_in    (addr_in),
        .m_rdata    (m_rdata),
        .r_rdata    (r_rdata),
        .switch_in  (switch_in),
        .key_in     (key_in),
        .addr_out   (addr_out),
        .write_data (write_data),
        .r_wdata    (r_wdata),
        .led_out    (led_out),
        .seg_an     (seg_an),
        .seg_out    (seg_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard
    string       tag_q[$];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %h required an expected entry", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) n_pass++;
            else $error("FAIL %s: observed %h required %h", t, obs, e);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        io_read   = 1'b0;
        io_write  = 1'b0;
    endtask

    task automatic io_wr(input logic [31:0] a, input logic [31:0] d);
        idle();
        io_write = 1'b1;
        addr_in  = a;
        r_rdata  = d;
        tick();
        idle();
    endtask

    // Combinational read in the current cycle, no clock edge consumed.
    task automatic io_rd_check(input string tag, input logic [31:0] a,
                               input logic [31:0] exp);
        idle();
        io_read = 1'b1;
        addr_in = a;
        expect_val(tag, exp);
        #1;
        check(r_wdata);
    endtask

    function automatic logic [7:0] seg_of(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
            4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
            4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
            4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Watchdog: the directed sequence is short; exceeding this means a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        key_in    = 1'b0;
        switch_in = 24'h0;
        addr_in   = 32'h0;
        m_rdata   = 32'h0;
        r_rdata   = 32'h0;
        idle();
        #2;

        // ---- reset state ----
        expect_val("rst_led", 32'h0);     check({8'h0, led_out});
        expect_val("rst_an", 32'hFE);     check({24'h0, seg_an});
        expect_val("rst_seg", 32'hC0);    check({24'h0, seg_out});
        expect_val("rst_rwdata", 32'h0);  check(r_wdata);
        tick();
        reset = 1'b0;
        tick();

        // ---- LED write / readback ----
        idle();
        io_write = 1'b1;
        addr_in  = 32'hFFFFFC60;
        r_rdata  = 32'h00ABCDEF;
        #1;
        expect_val("wdata_io", 32'h00ABCDEF); check(write_data);
        expect_val("addr_out", 32'hFFFFFC60); check(addr_out);
        tick();
        idle();
        expect_val("led_write", 32'h00ABCDEF); check({8'h0, led_out});
        io_rd_check("led_read", 32'hFFFFFC60, 32'h00ABCDEF);

        // ---- switches, ignored writes ----
        switch_in = 24'h123456;
        io_rd_check("sw_read", 32'hFFFFFC70, 32'h00123456);
        io_wr(32'hFFFFFC70, 32'hFFFFFFFF);
        io_wr(32'hFFFFFC90, 32'hFFFFFFFF);
        io_wr(32'hFFFFFCA0, 32'hFFFFFFFF);
        expect_val("led_after_ro_wr", 32'h00ABCDEF); check({8'h0, led_out});
        io_rd_check("sw_after_wr", 32'hFFFFFC70, 32'h00123456);
        io_rd_check("disp_after_wr", 32'hFFFFFC80, 32'h0);
        io_rd_check("key_after_wr", 32'hFFFFFC90, 32'h0);
        io_rd_check("non_io_addr", 32'h00000060, 32'h0);
        io_rd_check("unmapped", 32'hFFFFFCA0, 32'h0);

        // ---- memory read / idle ----
        idle();
        mem_read = 1'b1;
        addr_in  = 32'h00001000;
        m_rdata  = 32'hDEADBEEF;
        #1;
        expect_val("mem_read", 32'hDEADBEEF); check(r_wdata);
        idle();
        r_rdata = 32'h55AA55AA;
        #1;
        expect_val("idle_rwdata", 32'h0); check(r_wdata);
        expect_val("idle_wdata", 32'h0);  check(write_data);
        mem_write = 1'b1;
        #1;
        expect_val("mem_wdata", 32'h55AA55AA); check(write_data);
        idle();

        // ---- key flag: 3-edge latency, coincident set/clear, read-to-clear ----
        key_in = 1'b1;
        tick();
        tick();
        io_rd_check("key_2edges", 32'hFFFFFC90, 32'h0);
        tick();   // third edge: rising edge sets flag while the read clears
        io_rd_check("key_set_wins", 32'hFFFFFC90, 32'h1);
        tick();
        io_rd_check("key_cleared", 32'hFFFFFC90, 32'h0);
        idle();
        key_in = 1'b0;
        tick(); tick(); tick();
        io_rd_check("key_no_reedge", 32'hFFFFFC90, 32'h0);
        idle();

        // ---- async reset mid-scan with LED full and flag pending ----
        io_wr(32'hFFFFFC60, 32'h00FFFFFF);
        key_in = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        key_in = 1'b0;
        expect_val("led_full", 32'h00FFFFFF); check({8'h0, led_out});
        #2;
        reset = 1'b1;
        #1;
        expect_val("arst_led", 32'h0);  check({8'h0, led_out});
        expect_val("arst_an", 32'hFE);  check({24'h0, seg_an});
        expect_val("arst_seg", 32'hC0); check({24'h0, seg_out});
        tick();
        reset = 1'b0;

        // ---- scan: k = rising edges since reset release ----
        io_rd_check("arst_flag", 32'hFFFFFC90, 32'h0);
        expect_val("scan_an_k0", 32'hFE); check({24'h0, seg_an});
        tick();
        io_wr(32'hFFFFFC80, 32'h76543210);
        io_rd_check("disp_read", 32'hFFFFFC80, 32'h76543210);
        idle();
        for (int k = 2; k <= 36; k++) begin
            int idx;
            idx = (k / SCAN_DIV) % 8;
            expect_val($sformatf("scan_an_k%0d", k), {24'h0, ~(8'h01 << idx)});
            check({24'h0, seg_an});
            expect_val($sformatf("scan_seg_k%0d", k), {24'h0, seg_of(4'(idx))});
            check({24'h0, seg_out});
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
